forward_cell_link_arbiter: RTL and testbench
============================================

Name: forward_cell_link_arbiter

Overview:
- Packet-mode, round-robin merge of NUM_PORTS AXI-Stream inputs (incoming cell link, local BPM, local FMPS) onto one outgoing stream feeding the cell-link forwarding logic.
- Inputs have no TREADY, so each port is buffered in its own store-and-forward FIFO. A packet becomes eligible only once its TLAST has been written.
- Packets are never interleaved on the output.

Parameters:
- NUM_PORTS, 3, number of input streams (index 0 = cell link, 1 = local, 2 = FMPS).
- FIFO_AW, 8, log2 depth of each per-port FIFO (256 words).
- DATA_WIDTH, 32, stream data width.

Ports:
- auroraUserClk  in  1  single clock for all logic.
- auroraUserReset  in  1  synchronous, active-high reset.
- sTVALID  in  NUM_PORTS  per-port word valid; no backpressure.
- sTLAST  in  NUM_PORTS  per-port last word of packet.
- sTDATA  in  NUM_PORTS*DATA_WIDTH  port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- portEnable  in  NUM_PORTS  1 = port may be granted.
- mTVALID  out  1  merged output valid; sink always ready.
- mTLAST  out  1  merged output last.
- mTDATA  out  DATA_WIDTH  merged output data.
- overflow  out  NUM_PORTS  sticky per-port packet-dropped flag.

Behaviour:
- Reset values:
  - mTVALID=0, mTLAST=0, mTDATA=0, overflow=0.
  - All FIFO pointers and packet counters = 0.
  - Arbiter in IDLE with rrPtr=0.
- Reset mid-operation discards all buffered and in-flight packets. Inputs are ignored while reset is high.
- Per-port write side:
  - Each sTVALID word is written at wrPtr, and wrPtr increments.
  - On a TLAST write: commitPtr<=wrPtr+1 and pktCount increments.
  - If a word arrives while the FIFO is full (wrPtr+1==rdPtr modulo depth):
    - Rewind wrPtr to commitPtr and set overflow[p].
    - Enter DROP and discard words up to and including the next TLAST, then return to normal.
    - Committed packets are unaffected.
  - Single-word packets (TVALID and TLAST in the same cycle) are legal.
- Arbiter FSM:
  - IDLE:
    - Eligible port = pktCount!=0 && portEnable.
    - Grant the first eligible port searching rrPtr, rrPtr+1, … modulo NUM_PORTS.
    - On grant: rrPtr<=grant+1 (wraps to 0), go to STREAM.
    - If no port is eligible, stay in IDLE.
  - STREAM:
    - Pop one word per cycle from the granted FIFO into the output register: mTVALID=1, mTLAST=stored last bit.
    - When the popped word has last=1: decrement that port's pktCount and go to IDLE.
- Latency and throughput:
  - TLAST sampled at edge E0 → grant at E1 → first output word valid after E2.
  - Back-to-back packets have exactly one idle cycle between them.
- A commit and a pop on the same port in the same cycle leave pktCount unchanged.
- Deasserting portEnable mid-packet does not truncate the packet. The disabled port's FIFO keeps accepting writes.
- mTVALID is low every cycle not in STREAM.

Optional Feature:
- Macro: FORWARD_CELL_LINK_ARBITER_STATS_EN.
- When defined:
  - Adds output pktForwarded [NUM_PORTS*16], a per-port count of packets forwarded. Wraps at 16'hFFFF→0.
  - Adds output pktDropped [NUM_PORTS*16], per-port dropped-packet counters with the same wrap.
  - Both are cleared by reset.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package forward_cell_link_pkg holds:
  - Arbiter state typedef {IDLE, STREAM} and write-side state typedef {NORMAL, DROP}.
  - Port-index constants PORT_CELL=0, PORT_LOCAL=1, PORT_FMPS=2.
  - DATA_WIDTH constant.
- Sub-module forward_cell_link_pkt_fifo: one port's FIFO with commit/rewind logic, pktCount, overflow and DROP handling.
- The top level instantiates NUM_PORTS of these sub-modules plus the round-robin FSM.

Test Plan:
- Reset, then a 4-word packet (0xA5BE0000..0xA5BE0003) on port 0 → the same 4 words out consecutively; mTVALID rises 2 cycles after the TLAST edge; mTLAST only on 0xA5BE0003.
- 3-word packets on all three ports in the same cycle → output order port 0, 1, 2, one idle cycle between packets, no interleaving. Repeat → order continues 0, 1, 2 (rrPtr wrap).
- Single-word packet (TVALID=TLAST=1, 0x12345678) on port 1 → one output beat with mTLAST=1.
- Fill port 2 with 255 committed words, then send a 10-word packet → overflow[2]=1, the 10-word packet is never output, the prior packets are output intact, and the next packet is forwarded normally.
- portEnable[0]=0 with packets pending on ports 0 and 1 → only port 1 is output; re-enable → port 0 packet follows.
- Assert auroraUserReset for one cycle mid-STREAM of an 8-word packet → mTVALID=0 from the next cycle, no further words, overflow=0.

Source files
------------

// File: rtl/forward_cell_link_pkg.sv
// Shared types and constants for the forward cell-link arbiter.
//   arbState_t : round-robin arbiter states
//   wrState_t  : per-port FIFO write-side states
//   PORT_*     : input port indices
//   DATA_WIDTH : default stream data width
package forward_cell_link_pkg;

    localparam int PORT_CELL  = 0;
    localparam int PORT_LOCAL = 1;
    localparam int PORT_FMPS  = 2;

    localparam int DATA_WIDTH = 32;

    typedef enum logic {IDLE, STREAM} arbState_t;
    typedef enum logic {NORMAL, DROP} wrState_t;

endpackage

// File: rtl/forward_cell_link_pkt_fifo.sv
// Store-and-forward packet FIFO for one arbiter input port.
// Words are written unconditionally (no backpressure); a packet only counts
// as available once its TLAST word is committed. A word arriving while the
// FIFO is full rewinds the write pointer to the last commit point, raises the
// sticky overflow flag and discards the rest of that packet.
// Ports:
//   auroraUserClk, auroraUserReset : clock, synchronous active-high reset
//   wrValid, wrLast, wrData        : input stream word
//   rdEn                           : pop the word at the read pointer
//   rdData, rdLast                 : word at the read pointer (combinational)
//   pktAvail                       : at least one committed packet buffered
//   overflow                       : sticky packet-dropped flag
//   dropPulse                      : one-cycle strobe per dropped packet
module forward_cell_link_pkt_fifo #(
    parameter int FIFO_AW    = 8,
    parameter int DATA_WIDTH = forward_cell_link_pkg::DATA_WIDTH
) (
    input  logic                  auroraUserClk,
    input  logic                  auroraUserReset,
    input  logic                  wrValid,
    input  logic                  wrLast,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic                  rdEn,
    output logic [DATA_WIDTH-1:0] rdData,
    output logic                  rdLast,
    output logic                  pktAvail,
    output logic                  overflow,
    output logic                  dropPulse
);
    import forward_cell_link_pkg::*;

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);

    logic [DATA_WIDTH:0]  mem [DEPTH];
    logic [FIFO_AW-1:0]   wrPtr;
    logic [FIFO_AW-1:0]   commitPtr;
    logic [FIFO_AW-1:0]   rdPtr;
    logic [FIFO_AW:0]     pktCount;
    wrState_t             wrState;

    logic full;
    logic wrAccept;
    logic commit;
    logic popLast;

    assign full      = (wrPtr + PTR_ONE) == rdPtr;
    assign wrAccept  = !auroraUserReset && wrValid && (wrState == NORMAL) && !full;
    assign dropPulse = !auroraUserReset && wrValid && (wrState == NORMAL) && full;
    assign commit    = wrAccept && wrLast;

    assign {rdLast, rdData} = mem[rdPtr];
    assign popLast  = rdEn && rdLast;
    assign pktAvail = pktCount != '0;

    always_ff @(posedge auroraUserClk) begin
        if (wrAccept) begin
            mem[wrPtr] <= {wrLast, wrData};
        end
    end

    always_ff @(posedge auroraUserClk) begin
        if (auroraUserReset) begin
            wrPtr     <= '0;
            commitPtr <= '0;
            rdPtr     <= '0;
            pktCount  <= '0;
            overflow  <= 1'b0;
            wrState   <= NORMAL;
        end else begin
            if (rdEn) begin
                rdPtr <= rdPtr + PTR_ONE;
            end

            case (wrState)
                NORMAL: begin
                    if (wrValid) begin
                        if (full) begin
                            wrPtr    <= commitPtr;
                            overflow <= 1'b1;
                            // An overflowing TLAST word ends the packet by itself.
                            if (!wrLast) begin
                                wrState <= DROP;
                            end
                        end else begin
                            wrPtr <= wrPtr + PTR_ONE;
                            if (wrLast) begin
                                commitPtr <= wrPtr + PTR_ONE;
                            end
                        end
                    end
                end
                DROP: begin
                    if (wrValid && wrLast) begin
                        wrState <= NORMAL;
                    end
                end
                default: wrState <= NORMAL;
            endcase

            if (commit && !popLast) begin
                pktCount <= pktCount + CNT_ONE;
            end else if (!commit && popLast) begin
                pktCount <= pktCount - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/forward_cell_link_arbiter.sv
// Packet-mode round-robin merge of NUM_PORTS AXI-Stream inputs (cell link,
// local BPM, local FMPS) onto one stream for the cell-link forwarder.
// Each input is buffered in a store-and-forward FIFO; whole packets are
// forwarded without interleaving, one idle cycle between packets.
// Optional statistics counters: define FORWARD_CELL_LINK_ARBITER_STATS_EN.
// Ports:
//   auroraUserClk, auroraUserReset : clock, synchronous active-high reset
//   sTVALID, sTLAST, sTDATA        : per-port input streams (no TREADY)
//   portEnable                     : per-port grant enable
//   mTVALID, mTLAST, mTDATA        : merged output (sink always ready)
//   overflow                       : sticky per-port packet-dropped flags
//   pktForwarded, pktDropped       : per-port 16-bit counters (stats build)
module forward_cell_link_arbiter #(
    parameter int NUM_PORTS  = 3,
    parameter int FIFO_AW    = 8,
    parameter int DATA_WIDTH = forward_cell_link_pkg::DATA_WIDTH
) (
    input  logic                            auroraUserClk,
    input  logic                            auroraUserReset,
    input  logic [NUM_PORTS-1:0]            sTVALID,
    input  logic [NUM_PORTS-1:0]            sTLAST,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] sTDATA,
    input  logic [NUM_PORTS-1:0]            portEnable,
    output logic                            mTVALID,
    output logic                            mTLAST,
    output logic [DATA_WIDTH-1:0]           mTDATA,
    output logic [NUM_PORTS-1:0]            overflow
`ifdef FORWARD_CELL_LINK_ARBITER_STATS_EN
    ,
    output logic [NUM_PORTS*16-1:0]         pktForwarded,
    output logic [NUM_PORTS*16-1:0]         pktDropped
`endif
);
    import forward_cell_link_pkg::*;

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arbState_t             state;
    arbState_t             nextState;
    logic [PW-1:0]         rrPtr;
    logic [PW-1:0]         nextRrPtr;
    logic [PW-1:0]         grant;
    logic [PW-1:0]         nextGrant;

    logic [NUM_PORTS-1:0]  pktAvail;
    logic [NUM_PORTS-1:0]  pop;
    logic [NUM_PORTS-1:0]  dropPulse;
    logic [NUM_PORTS-1:0]  fifoLast;
    logic [DATA_WIDTH-1:0] fifoData [NUM_PORTS];

    logic                  selLast;
    logic [DATA_WIDTH-1:0] selData;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
        forward_cell_link_pkt_fifo #(
            .FIFO_AW    (FIFO_AW),
            .DATA_WIDTH (DATA_WIDTH)
        ) uFifo (
            .auroraUserClk   (auroraUserClk),
            .auroraUserReset (auroraUserReset),
            .wrValid         (sTVALID[p]),
            .wrLast          (sTLAST[p]),
            .wrData          (sTDATA[p*DATA_WIDTH +: DATA_WIDTH]),
            .rdEn            (pop[p]),
            .rdData          (fifoData[p]),
            .rdLast          (fifoLast[p]),
            .pktAvail        (pktAvail[p]),
            .overflow        (overflow[p]),
            .dropPulse       (dropPulse[p])
        );
    end

    assign selData = fifoData[grant];
    assign selLast = fifoLast[grant];

    always_ff @(posedge auroraUserClk) begin
        if (auroraUserReset) begin
            state <= IDLE;
            rrPtr <= '0;
            grant <= '0;
        end else begin
            state <= nextState;
            rrPtr <= nextRrPtr;
            grant <= nextGrant;
        end
    end

    always_comb begin
        logic          found;
        int unsigned   idx;
        logic [PW-1:0] idxP;

        nextState = state;
        nextRrPtr = rrPtr;
        nextGrant = grant;
        pop       = '0;
        found     = 1'b0;
        idx       = 0;
        idxP      = '0;

        case (state)
            IDLE: begin
                // First eligible port at or after rrPtr, modulo NUM_PORTS.
                for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                    idx  = (32'(rrPtr) + i) % NUM_PORTS;
                    idxP = PW'(idx);
                    if (!found && pktAvail[idxP] && portEnable[idxP]) begin
                        found     = 1'b1;
                        nextGrant = idxP;
                        nextRrPtr = (idx + 1 == 32'(NUM_PORTS)) ? '0 : PW'(idx + 1);
                        nextState = STREAM;
                    end
                end
            end
            STREAM: begin
                pop[grant] = 1'b1;
                if (selLast) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge auroraUserClk) begin
        if (auroraUserReset) begin
            mTVALID <= 1'b0;
            mTLAST  <= 1'b0;
            mTDATA  <= '0;
        end else if (state == STREAM) begin
            mTVALID <= 1'b1;
            mTLAST  <= selLast;
            mTDATA  <= selData;
        end else begin
            mTVALID <= 1'b0;
            mTLAST  <= 1'b0;
        end
    end

`ifdef FORWARD_CELL_LINK_ARBITER_STATS_EN
    always_ff @(posedge auroraUserClk) begin
        if (auroraUserReset) begin
            pktForwarded <= '0;
            pktDropped   <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (pop[p] && fifoLast[p]) begin
                    pktForwarded[p*16 +: 16] <= pktForwarded[p*16 +: 16] + 16'd1;
                end
                if (dropPulse[p]) begin
                    pktDropped[p*16 +: 16] <= pktDropped[p*16 +: 16] + 16'd1;
                end
            end
        end
    end
`else
    // Drop strobes only feed the statistics counters.
    logic unusedDropPulse;
    assign unusedDropPulse = ^dropPulse;
`endif

endmodule

// File: tb/tb_forward_cell_link_arbiter.sv
module tb_forward_cell_link_arbiter;

    localparam int NP = 3;
    localparam int DW = 32;

    logic                auroraUserClk = 1'b0;
    logic                auroraUserReset;
    logic [NP-1:0]       sTVALID;
    logic [NP-1:0]       sTLAST;
    logic [NP*DW-1:0]    sTDATA;
    logic [NP-1:0]       portEnable;
    logic                mTVALID;
    logic                mTLAST;
    logic [DW-1:0]       mTDATA;
    logic [NP-1:0]       overflow;
`ifdef FORWARD_CELL_LINK_ARBITER_STATS_EN
    logic [NP*16-1:0]    pktForwarded;
    logic [NP*16-1:0]    pktDropped;
`endif

    always #5 auroraUserClk = ~auroraUserClk;

    forward_cell_link_arbiter #(
        .NUM_PORTS  (NP),
        .FIFO_AW    (8),
        .DATA_WIDTH (DW)
    ) dut (
        .auroraUserClk   (auroraUserClk),
        .auroraUserReset (auroraUserReset),
        .sTVALID         (sTVALID),
        .sTLAST          (sTLAST),
        .sTDATA          (sTDATA),
        .portEnable      (portEnable),
        .mTVALID         (mTVALID),
        .mTLAST          (mTLAST),
        .mTDATA          (mTDATA),
        .overflow        (overflow)
`ifdef FORWARD_CELL_LINK_ARBITER_STATS_EN
        ,
        .pktForwarded    (pktForwarded),
        .pktDropped      (pktDropped)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int beats  = 0;

    logic [DW:0] sb [$];
    int pktStart [$];
    int pktEnd   [$];

    always @(posedge auroraUserClk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every valid beat must match the head of the scoreboard.
    initial begin : monitor
        bit          inPkt;
        logic [DW:0] e;
        inPkt = 1'b0;
        forever begin
            @(negedge auroraUserClk);
            if (mTVALID === 1'b1) begin
                if (!inPkt) pktStart.push_back(cyc);
                inPkt = !mTLAST;
                if (mTLAST) pktEnd.push_back(cyc);
                beats++;
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpectedBeat: observed 0x%0h expected no beat", {mTLAST, mTDATA});
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("beat", 64'({mTLAST, mTDATA}), 64'(e));
                end
            end
        end
    end

    task automatic idleInputs();
        sTVALID = '0;
        sTLAST  = '0;
        sTDATA  = '0;
    endtask

    task automatic doReset();
        @(negedge auroraUserClk);
        auroraUserReset = 1'b1;
        idleInputs();
        @(negedge auroraUserClk);
        auroraUserReset = 1'b0;
    endtask

    task automatic pushExp(input int n, input logic [DW-1:0] base);
        logic l;
        for (int i = 0; i < n; i++) begin
            l = (i == n - 1);
            sb.push_back({l, base + 32'(i)});
        end
    endtask

    task automatic sendPkt(input int p, input int n, input logic [DW-1:0] base,
                           input bit expectOut, output int tlastCyc);
        if (expectOut) pushExp(n, base);
        for (int i = 0; i < n; i++) begin
            @(negedge auroraUserClk);
            sTVALID[p] = 1'b1;
            sTLAST[p]  = (i == n - 1);
            sTDATA[p*DW +: DW] = base + 32'(i);
        end
        @(negedge auroraUserClk);
        sTVALID[p] = 1'b0;
        sTLAST[p]  = 1'b0;
        tlastCyc   = cyc;
    endtask

    task automatic sendAll3(input logic [DW-1:0] base);
        for (int p = 0; p < NP; p++) pushExp(3, base + 32'(p * 256));
        for (int i = 0; i < 3; i++) begin
            @(negedge auroraUserClk);
            sTVALID = '1;
            sTLAST  = (i == 2) ? '1 : '0;
            for (int p = 0; p < NP; p++) sTDATA[p*DW +: DW] = base + 32'(p * 256 + i);
        end
        @(negedge auroraUserClk);
        idleInputs();
    endtask

    task automatic drain(input string tag, input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) @(negedge auroraUserClk);
        repeat (4) @(negedge auroraUserClk);
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic checkGaps(input string tag);
        for (int k = 1; k < pktStart.size() && k <= pktEnd.size(); k++)
            chk(tag, 64'(pktStart[k] - pktEnd[k-1]), 64'd2);
    endtask

    initial begin
        int tl;
        int b0;

        auroraUserReset = 1'b1;
        portEnable      = '1;
        idleInputs();
        repeat (3) @(negedge auroraUserClk);
        auroraUserReset = 1'b0;
        @(negedge auroraUserClk);

        chk("rstValid", 64'(mTVALID), 64'd0);
        chk("rstLast", 64'(mTLAST), 64'd0);
        chk("rstData", 64'(mTDATA), 64'd0);
        chk("rstOverflow", 64'(overflow), 64'd0);

        // 4-word packet on the cell-link port, latency from TLAST edge.
        pktStart.delete(); pktEnd.delete();
        sendPkt(0, 4, 32'hA5BE0000, 1'b1, tl);
        drain("t1Drain", 50);
        chk("t1PktCount", 64'(pktStart.size()), 64'd1);
        chk("t1Latency", 64'((pktStart.size() > 0) ? pktStart[0] - tl : -1), 64'd2);

        // Simultaneous packets on all ports from rrPtr=0, twice.
        doReset();
        pktStart.delete(); pktEnd.delete();
        sendAll3(32'h30000000);
        drain("t2aDrain", 60);
        chk("t2aPktCount", 64'(pktStart.size()), 64'd3);
        checkGaps("t2aGap");
        pktStart.delete(); pktEnd.delete();
        sendAll3(32'h40000000);
        drain("t2bDrain", 60);
        chk("t2bPktCount", 64'(pktStart.size()), 64'd3);
        checkGaps("t2bGap");

        // Single-word packet.
        pktStart.delete(); pktEnd.delete();
        sendPkt(1, 1, 32'h12345678, 1'b1, tl);
        drain("t3Drain", 50);
        chk("t3PktEnds", 64'(pktEnd.size()), 64'd1);

        // Fill port 2 with 255 committed words, then overflow it.
        portEnable = 3'b011;
        for (int k = 0; k < 15; k++) sendPkt(2, 17, 32'h50000000 + 32'(k * 256), 1'b1, tl);
        chk("t4NoOverflowYet", 64'(overflow), 64'd0);
        sendPkt(2, 10, 32'h5F000000, 1'b0, tl);
        chk("t4Overflow", 64'(overflow), 64'b100);
        portEnable = 3'b111;
        drain("t4DrainFill", 2000);
        sendPkt(2, 5, 32'h60000000, 1'b1, tl);
        drain("t4DrainNext", 50);
        chk("t4OverflowSticky", 64'(overflow), 64'b100);
`ifdef FORWARD_CELL_LINK_ARBITER_STATS_EN
        chk("t4Dropped", 64'(pktDropped[47:32]), 64'd1);
        chk("t4Forwarded", 64'(pktForwarded[47:32]), 64'd18);
`endif

        // Disabled port 0 is skipped until re-enabled.
        portEnable = 3'b110;
        sendPkt(0, 4, 32'h70000000, 1'b0, tl);
        sendPkt(1, 4, 32'h71000000, 1'b1, tl);
        drain("t5DrainPort1", 50);
        repeat (10) @(negedge auroraUserClk);
        pushExp(4, 32'h70000000);
        portEnable = 3'b111;
        drain("t5DrainPort0", 50);

        // Reset in the middle of an 8-word packet.
        sendPkt(0, 8, 32'h80000000, 1'b1, tl);
        b0 = beats;
        for (int i = 0; i < 50 && beats - b0 < 3; i++) @(negedge auroraUserClk);
        chk("t6Started", 64'(beats - b0 >= 3), 64'd1);
        @(posedge auroraUserClk);
        #1 auroraUserReset = 1'b1;
        @(negedge auroraUserClk);
        #1 sb.delete();
        @(posedge auroraUserClk);
        #1 auroraUserReset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge auroraUserClk);
            chk("t6ValidLow", 64'(mTVALID), 64'd0);
        end
        chk("t6Overflow", 64'(overflow), 64'd0);

        // Recovery after reset.
        sendPkt(1, 2, 32'h90000000, 1'b1, tl);
        drain("t7Drain", 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
